fibo_requester: RTL and testbench
=================================

Name: fibo_requester

Overview:
- Initiator side of the fibonacci begin/done interface.
- Accepts a sequence command (start index, count) on a valid/ready port. Drives begin_fibo/input_s into a fibonacci calculator for each index in turn, then waits for done and captures fibo_out.
- Streams each result with its index on a valid/ready output. Adds a wait timeout and an overflow flag.
- Sits between the lab host/test harness and the fibonacci calculator.

Parameters:
- TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT per request before the sequence aborts (range 2..1023).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when high with cmd_valid
- cmd_start  input  5  first fibonacci index
- cmd_count  input  5  number of indices to request; 0 = none
- begin_fibo  output  1  one-cycle start pulse to calculator
- input_s  output  5  index to calculator
- fibo_out  input  16  calculator result
- done  input  1  calculator completion (pulse or level)
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_data  output  16  captured fibo_out
- res_index  output  5  index of res_data
- res_ovf  output  1  res_index > 24 (true value exceeds 16 bits)
- res_last  output  1  final result of the command
- busy  output  1  high in any state except IDLE
- timeout_err  output  1  sticky abort flag

Behaviour:
- Indexing convention: F(0)=0, F(1)=1. F(24)=46368 is the largest value that fits in 16 bits.
- Reset values: state IDLE; begin_fibo=0; input_s=0; res_valid=0; res_data=0; res_index=0; res_ovf=0; res_last=0; busy=0; timeout_err=0. All outputs are registered.
- Reset mid-operation: any in-flight request is abandoned and no result is emitted.
- States are IDLE, ISSUE, WAIT, EMIT.
- IDLE:
  - cmd_ready=1 in IDLE only.
  - On cmd_valid&cmd_ready: latch cur_idx=cmd_start and remaining=cmd_count, and clear timeout_err.
  - If cmd_count==0, remain in IDLE and emit nothing. Otherwise go to ISSUE.
- ISSUE (exactly one cycle):
  - begin_fibo=1 and input_s=cur_idx.
  - Clear the wait counter and the armed flag.
  - Go to WAIT.
- input_s stays stable from ISSUE through the end of WAIT.
- WAIT:
  - begin_fibo=0.
  - armed sets on any cycle in ISSUE or WAIT where done==0 is sampled.
  - Result qualifies on the first WAIT cycle with done==1 and armed==1. This rejects a stale level-held done left over from the previous operation.
  - On qualify: res_data<=fibo_out, res_index<=cur_idx, res_ovf<=(cur_idx>24), res_last<=(remaining==1); go to EMIT.
  - Wait counter increments each WAIT cycle. If it reaches TIMEOUT_CYCLES with no qualify: timeout_err<=1, remaining<=0, go to IDLE, no result emitted.
  - Qualify and timeout in the same cycle: qualify wins.
- EMIT:
  - res_valid=1, with res_data, res_index, res_ovf and res_last held stable until res_ready.
  - On handshake: res_valid<=0 and remaining<=remaining-1.
  - If remaining was 1, go to IDLE. Otherwise cur_idx<=cur_idx+1 (modulo 32, so 31 wraps to 0) and go to ISSUE.
- Latency:
  - Command accept at cycle t gives begin_fibo at t+1.
  - Qualify at cycle d gives res_valid at d+1.
  - Handshake at cycle h gives the next begin_fibo at h+1.
- cmd_valid outside IDLE is ignored; the command is not latched.
- res_ready while res_valid==0 has no effect.

Decomposition:
- Package fibo_pkg:
  - FIBO_IDX_W=5, FIBO_DATA_W=16, FIBO_MAX_EXACT_IDX=24.
  - typedef enum logic [1:0] req_state_t {IDLE, ISSUE, WAIT, EMIT}.
- Sub-module fibo_wait_timer, parameterised by TIMEOUT_CYCLES:
  - Inputs clr and en.
  - Output expired is registered and goes high when the count reaches TIMEOUT_CYCLES.
- Bench: the behavioural fibonacci calculator model lives in the testbench, not the RTL.

Test Plan:
- Single request: start=10, count=1, model answers 5 cycles after begin → begin_fibo pulses once with input_s=10; one result res_data=55, res_index=10, res_last=1, res_ovf=0; then cmd_ready returns high.
- Sequence: start=5, count=3, res_ready tied 1 → results 5, 8, 13 on indices 5, 6, 7; res_last only on 7; exactly 3 begin_fibo pulses.
- Boundary and wrap: start=24, count=2 → 46368 with ovf=0, then idx 25 with ovf=1. Separately start=30, count=3 → indices 30, 31, 0 with F(0)=0.
- Backpressure and stale done:
  - res_ready held low 10 cycles → res_valid and all result fields stable; no new begin_fibo until the handshake.
  - Model holds done high from the previous op for 2 cycles after begin → not qualified; correct value captured after the done re-rise.
- Timeout: TIMEOUT_CYCLES=8, model never asserts done → timeout_err=1 by cycle begin+9; no res_valid; back in IDLE. The next command clears timeout_err and completes normally.
- Reset mid-WAIT, and count=0:
  - rst_n low for 1 cycle during WAIT → all outputs at reset values next cycle; a late done from the model is ignored.
  - cmd_count=0 → accepted; no begin_fibo, no result.

Source files
------------

// File: rtl/fibo_pkg.sv
// Shared definitions for the fibonacci requester.
// Widths of the index/result buses, the largest index whose true value
// still fits the result bus, and the requester FSM state encoding.
package fibo_pkg;

  localparam int FIBO_IDX_W         = 5;
  localparam int FIBO_DATA_W        = 16;
  localparam int FIBO_MAX_EXACT_IDX = 24;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    EMIT
  } req_state_t;

endpackage

// File: rtl/fibo_wait_timer.sv
// Per-request wait timer for the fibonacci requester.
// Counts enabled cycles since the last clear. expired is registered and is
// high during the TIMEOUT_CYCLES-th enabled cycle (counting that cycle
// itself), then stays high until the next clear.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : restart the count (takes priority over en)
//   en         : count this cycle
//   expired    : timeout reached
module fibo_wait_timer #(
  parameter int TIMEOUT_CYCLES = 64  // 2..1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = 10;
  // Raised one cycle early so the flag is already visible in the final
  // allowed cycle rather than the one after it.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: reset is synchronous (sampled on clk) and all state uses
  // non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else if (en && !expired) begin
      // The count freezes once expired so it can never wrap.
      cnt     <= cnt + 1'b1;
      expired <= (cnt + 1'b1 == LAST);
    end
  end

endmodule

// File: rtl/fibo_requester.sv
// Initiator side of the fibonacci begin/done interface.
// Accepts (start, count) commands, issues each index to the calculator with
// a one-cycle begin_fibo pulse, waits for a qualified done, and streams each
// result with its index on a valid/ready port. A stuck calculator aborts the
// sequence after TIMEOUT_CYCLES wait cycles and sets a sticky timeout_err.
//   cmd_valid/cmd_ready, cmd_start, cmd_count : command port (count 0 = none)
//   begin_fibo, input_s                       : request to calculator
//   fibo_out, done                            : calculator response
//   res_valid/res_ready, res_data, res_index,
//   res_ovf, res_last                         : result stream
//   busy                                      : not in IDLE
//   timeout_err                               : sticky, cleared by next command
module fibo_requester
  import fibo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64  // 2..1023
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [FIBO_IDX_W-1:0]  cmd_start,
  input  logic [FIBO_IDX_W-1:0]  cmd_count,
  output logic                   begin_fibo,
  output logic [FIBO_IDX_W-1:0]  input_s,
  input  logic [FIBO_DATA_W-1:0] fibo_out,
  input  logic                   done,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [FIBO_DATA_W-1:0] res_data,
  output logic [FIBO_IDX_W-1:0]  res_index,
  output logic                   res_ovf,
  output logic                   res_last,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam logic [FIBO_IDX_W-1:0] OVF_LIMIT = FIBO_IDX_W'(FIBO_MAX_EXACT_IDX);
  localparam logic [FIBO_IDX_W-1:0] ONE       = FIBO_IDX_W'(1);

  req_state_t            state, state_next;
  logic [FIBO_IDX_W-1:0] cur_idx, remaining, issue_idx;
  logic                  armed, qualify, expired;

  fibo_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state == ISSUE),
    .en      (state == WAIT),
    .expired (expired)
  );

  // A done only counts once the calculator has been seen with done low since
  // this request was issued; a level-held done from the previous request is
  // therefore never mistaken for the new result.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch forms.
    state_next = state;
    qualify    = 1'b0;
    issue_idx  = (state == IDLE) ? cmd_start : cur_idx + 1'b1;
    case (state)
      IDLE:  if (cmd_valid && cmd_count != '0) state_next = ISSUE;
      ISSUE: state_next = WAIT;
      WAIT: begin
        qualify = done && armed;
        // Qualify is tested first so it wins over a simultaneous timeout.
        if (qualify)      state_next = EMIT;
        else if (expired) state_next = IDLE;
      end
      EMIT:  if (res_ready) state_next = (remaining == ONE) ? IDLE : ISSUE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      begin_fibo  <= 1'b0;
      input_s     <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_index   <= '0;
      res_ovf     <= 1'b0;
      res_last    <= 1'b0;
      timeout_err <= 1'b0;
      cur_idx     <= '0;
      remaining   <= '0;
      armed       <= 1'b0;
    end else begin
      state <= state_next;
      // Status outputs are registered from the next state so they line up
      // with the state they describe.
      cmd_ready  <= (state_next == IDLE);
      busy       <= (state_next != IDLE);
      begin_fibo <= (state_next == ISSUE);
      res_valid  <= (state_next == EMIT);
      // input_s only changes on entry to ISSUE, so it holds through WAIT.
      if (state_next == ISSUE) input_s <= issue_idx;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cur_idx     <= cmd_start;
            remaining   <= cmd_count;
            timeout_err <= 1'b0;
          end
        end
        ISSUE: armed <= !done;
        WAIT: begin
          if (!done) armed <= 1'b1;
          if (qualify) begin
            res_data  <= fibo_out;
            res_index <= cur_idx;
            res_ovf   <= (cur_idx > OVF_LIMIT);
            res_last  <= (remaining == ONE);
          end else if (expired) begin
            timeout_err <= 1'b1;
            remaining   <= '0;
          end
        end
        EMIT: begin
          if (res_ready) begin
            remaining <= remaining - 1'b1;
            if (remaining != ONE) cur_idx <= cur_idx + 1'b1;  // wraps 31 -> 0
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fibo_requester.sv
// Directed testbench for fibo_requester with a behavioural fibonacci
// calculator model (configurable latency, pulse/level done, stale done,
// never-answers).
module tb_fibo_requester;
  import fibo_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_start = '0;
  logic [4:0]  cmd_count = '0;
  logic        begin_fibo;
  logic [4:0]  input_s;
  logic [15:0] fibo_out;
  logic        done;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic [4:0]  res_index;
  logic        res_ovf;
  logic        res_last;
  logic        busy;
  logic        timeout_err;

  fibo_requester #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_count(cmd_count), .begin_fibo(begin_fibo),
    .input_s(input_s), .fibo_out(fibo_out), .done(done), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_index(res_index),
    .res_ovf(res_ovf), .res_last(res_last), .busy(busy),
    .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int begin_cnt = 0;
  int base;

  typedef struct {
    logic [15:0] data;
    logic [4:0]  idx;
    logic        ovf;
    logic        last;
  } res_t;
  res_t results[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] fib(input logic [4:0] n);
    logic [15:0] a = 16'd0;
    logic [15:0] b = 16'd1;
    logic [15:0] t;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Calculator model: reacts to begin_fibo, answers model_lat cycles later.
  int          since = 1000;
  int          model_lat = 5;
  int          stale_hold = 0;
  bit          model_level = 1'b0;
  bit          model_never = 1'b0;
  logic [15:0] cur_val = '0;
  logic [15:0] prev_val = '0;
  bit          resp, stale;

  initial begin
    done = 1'b0;
    fibo_out = '0;
    forever begin
      @(negedge clk);
      if (begin_fibo) begin
        since = 0;
        prev_val = cur_val;
        cur_val = fib(input_s);
      end else if (since < 1000) begin
        since++;
      end
      resp = !model_never && (model_level ? (since >= model_lat) : (since == model_lat));
      stale = since < stale_hold;
      done = resp || stale;
      fibo_out = resp ? cur_val : (stale ? prev_val : 16'hBEEF);
    end
  end

  // Monitor: count issue pulses, record completed result handshakes.
  initial forever begin
    @(negedge clk);
    if (rst_n && begin_fibo) begin_cnt++;
    if (rst_n && res_valid && res_ready)
      results.push_back('{data: res_data, idx: res_index, ovf: res_ovf, last: res_last});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [4:0] s, input logic [4:0] c);
    for (int i = 0; i < 100 && !cmd_ready; i++) tick();
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_start = s;
    cmd_count = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && !(cmd_ready && !busy); i++) tick();
    check(tag, cmd_ready && !busy, 1);
  endtask

  task automatic check_result(input string tag, input int n, input logic [15:0] d,
                              input logic [4:0] idx, input logic ovf, input logic last);
    res_t r;
    r = '{data: 'x, idx: 'x, ovf: 1'bx, last: 1'bx};
    if (n < results.size()) r = results[n];
    check({tag, "_data"}, r.data, d);
    check({tag, "_idx"}, r.idx, idx);
    check({tag, "_ovf"}, r.ovf, ovf);
    check({tag, "_last"}, r.last, last);
  endtask

  task automatic check_reset_outputs(input string p);
    check({p, "_cmd_ready"}, cmd_ready, 1);
    check({p, "_begin_fibo"}, begin_fibo, 0);
    check({p, "_input_s"}, input_s, 0);
    check({p, "_res_valid"}, res_valid, 0);
    check({p, "_res_data"}, res_data, 0);
    check({p, "_res_index"}, res_index, 0);
    check({p, "_res_ovf"}, res_ovf, 0);
    check({p, "_res_last"}, res_last, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Single request: F(10)=55, answer 5 cycles after begin
    results.delete();
    base = begin_cnt;
    send_cmd(5'd10, 5'd1);
    check("t1_begin", begin_fibo, 1);
    check("t1_input_s", input_s, 10);
    check("t1_busy", busy, 1);
    check("t1_cmd_ready_low", cmd_ready, 0);
    tick();
    check("t1_pulse_one_cycle", begin_fibo, 0);
    repeat (4) tick();
    check("t1_no_early_valid", res_valid, 0);
    check("t1_input_s_stable", input_s, 10);
    tick();
    check("t1_res_valid", res_valid, 1);
    check("t1_res_data", res_data, 55);
    check("t1_res_index", res_index, 10);
    check("t1_res_last", res_last, 1);
    check("t1_res_ovf", res_ovf, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("t1_valid_drop", res_valid, 0);
    check("t1_cmd_ready_back", cmd_ready, 1);
    check("t1_begin_count", begin_cnt - base, 1);

    // Sequence 5,6,7 with res_ready tied high
    results.delete();
    base = begin_cnt;
    res_ready = 1'b1;
    send_cmd(5'd5, 5'd3);
    wait_idle("t2_idle");
    check("t2_count", results.size(), 3);
    check_result("t2_r0", 0, 16'd5, 5'd5, 1'b0, 1'b0);
    check_result("t2_r1", 1, 16'd8, 5'd6, 1'b0, 1'b0);
    check_result("t2_r2", 2, 16'd13, 5'd7, 1'b0, 1'b1);
    check("t2_begin_count", begin_cnt - base, 3);

    // Overflow boundary: F(24)=46368 exact, F(25) mod 2^16 = 9489 flagged
    results.delete();
    send_cmd(5'd24, 5'd2);
    wait_idle("t3a_idle");
    check("t3a_count", results.size(), 2);
    check_result("t3a_r0", 0, 16'd46368, 5'd24, 1'b0, 1'b0);
    check_result("t3a_r1", 1, 16'd9489, 5'd25, 1'b1, 1'b1);

    // Index wrap 30, 31, 0
    results.delete();
    send_cmd(5'd30, 5'd3);
    wait_idle("t3b_idle");
    check("t3b_count", results.size(), 3);
    check_result("t3b_r0", 0, 16'd45608, 5'd30, 1'b1, 1'b0);
    check_result("t3b_r1", 1, 16'd35549, 5'd31, 1'b1, 1'b0);
    check_result("t3b_r2", 2, 16'd0, 5'd0, 1'b0, 1'b1);

    // Backpressure: result held for 10 cycles, no new issue meanwhile
    results.delete();
    res_ready = 1'b0;
    send_cmd(5'd3, 5'd2);
    for (int i = 0; i < 50 && !res_valid; i++) tick();
    check("t4_valid", res_valid, 1);
    base = begin_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t4_hold_valid", res_valid, 1);
      check("t4_hold_data", res_data, 2);
      check("t4_hold_begin", begin_fibo, 0);
    end
    check("t4_hold_index", res_index, 3);
    check("t4_hold_last", res_last, 0);
    check("t4_hold_ovf", res_ovf, 0);
    check("t4_no_issue", begin_cnt - base, 0);
    res_ready = 1'b1;
    tick();
    check("t4_next_begin", begin_fibo, 1);
    check("t4_next_input_s", input_s, 4);
    check("t4_valid_drop", res_valid, 0);
    wait_idle("t4_idle");
    check("t4_count", results.size(), 2);
    check_result("t4_r0", 0, 16'd2, 5'd3, 1'b0, 1'b0);
    check_result("t4_r1", 1, 16'd3, 5'd4, 1'b0, 1'b1);

    // Stale level-held done for 2 cycles after begin must be rejected
    results.delete();
    model_level = 1'b1;
    stale_hold = 2;
    send_cmd(5'd8, 5'd2);
    check("t5_begin", begin_fibo, 1);
    repeat (5) tick();
    check("t5_stale_rejected", res_valid, 0);
    tick();
    check("t5_valid", res_valid, 1);
    check("t5_data", res_data, 21);
    wait_idle("t5_idle");
    check("t5_count", results.size(), 2);
    check_result("t5_r0", 0, 16'd21, 5'd8, 1'b0, 1'b0);
    check_result("t5_r1", 1, 16'd34, 5'd9, 1'b0, 1'b1);
    model_level = 1'b0;
    stale_hold = 0;

    // Timeout after 8 wait cycles, then a clean command clears the flag
    results.delete();
    model_never = 1'b1;
    send_cmd(5'd1, 5'd1);
    check("t6_begin", begin_fibo, 1);
    repeat (8) tick();
    check("t6_not_yet", timeout_err, 0);
    check("t6_busy", busy, 1);
    tick();
    check("t6_timeout_err", timeout_err, 1);
    check("t6_idle_busy", busy, 0);
    check("t6_idle_ready", cmd_ready, 1);
    check("t6_no_valid", res_valid, 0);
    check("t6_no_result", results.size(), 0);
    model_never = 1'b0;
    send_cmd(5'd2, 5'd1);
    check("t6_err_cleared", timeout_err, 0);
    wait_idle("t6_idle");
    check("t6_count", results.size(), 1);
    check_result("t6_r0", 0, 16'd1, 5'd2, 1'b0, 1'b1);

    // Reset during WAIT: request abandoned, late done ignored
    results.delete();
    send_cmd(5'd12, 5'd2);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("t7");
    rst_n = 1'b1;
    base = begin_cnt;
    repeat (6) tick();
    check("t7_no_valid", res_valid, 0);
    check("t7_not_busy", busy, 0);
    check("t7_no_result", results.size(), 0);
    check("t7_no_issue", begin_cnt - base, 0);

    // count=0: accepted, nothing issued or emitted
    base = begin_cnt;
    send_cmd(5'd9, 5'd0);
    check("t8_ready", cmd_ready, 1);
    check("t8_busy", busy, 0);
    check("t8_begin", begin_fibo, 0);
    repeat (5) tick();
    check("t8_no_issue", begin_cnt - base, 0);
    check("t8_no_result", results.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
